// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Raster timing bundle between the VGA timing generator (master) and the
//   pattern controller (slave).
//   Signals:
//     mode       controller -> generator  requested timing, 0=640x480, 1=1440x900(h/4)
//     o_hpos     generator -> controller  horizontal counter
//     o_vpos     generator -> controller  vertical counter
//     o_hsync    generator -> controller  horizontal sync at the active mode's polarity
//     o_vsync    generator -> controller  vertical sync at the active mode's polarity
//     o_hblank   generator -> controller  horizontal blanking
//     o_vblank   generator -> controller  vertical blanking
//     o_visible  generator -> controller  pixel is inside the visible area
//     o_hmax     generator -> controller  last pixel of the line
//     o_vmax     generator -> controller  last line of the frame
//     o_mode     generator -> controller  timing mode currently in effect
interface vga_timing_gen_if;
    logic       mode;
    logic [9:0] o_hpos;
    logic [9:0] o_vpos;
    logic       o_hsync;
    logic       o_vsync;
    logic       o_hblank;
    logic       o_vblank;
    logic       o_visible;
    logic       o_hmax;
    logic       o_vmax;
    logic       o_mode;

    modport master (
        input  mode,
        output o_hpos, o_vpos, o_hsync, o_vsync, o_hblank, o_vblank,
               o_visible, o_hmax, o_vmax, o_mode
    );

    modport slave (
        output mode,
        input  o_hpos, o_vpos, o_hsync, o_vsync, o_hblank, o_vblank,
               o_visible, o_hmax, o_vmax, o_mode
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Free-running VGA raster timing generator. Walks the pixel position one step
//   per clock and decodes sync, blanking, visible and end-of-line/frame flags
//   for either 640x480@60 or 1440x900@60 at quarter horizontal resolution.
//   Ports:
//     clk    pixel clock
//     rst_n  asynchronous active-low reset
//     vga    timing bundle (master side): mode in; o_hpos, o_vpos, o_hsync,
//            o_vsync, o_hblank, o_vblank, o_visible, o_hmax, o_vmax, o_mode out
//   Parameter:
//     REG_OUT  1: flags registered from next-state counters; 0: decoded
//              combinationally from the current counters. Same cycle alignment.
module vga_timing_gen #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_timing_gen_if.master   vga
);

    // Mode 0: 640x480@60
    localparam logic [9:0] M0_HVIS  = 10'd640;
    localparam logic [9:0] M0_HS0   = 10'd656;
    localparam logic [9:0] M0_HS1   = 10'd752;
    localparam logic [9:0] M0_HLAST = 10'd799;
    localparam logic [9:0] M0_VVIS  = 10'd480;
    localparam logic [9:0] M0_VS0   = 10'd490;
    localparam logic [9:0] M0_VS1   = 10'd492;
    localparam logic [9:0] M0_VLAST = 10'd524;
    // Mode 1: 1440x900@60, horizontal divided by 4
    localparam logic [9:0] M1_HVIS  = 10'd360;
    localparam logic [9:0] M1_HS0   = 10'd380;
    localparam logic [9:0] M1_HS1   = 10'd418;
    localparam logic [9:0] M1_HLAST = 10'd475;
    localparam logic [9:0] M1_VVIS  = 10'd900;
    localparam logic [9:0] M1_VS0   = 10'd901;
    localparam logic [9:0] M1_VS1   = 10'd904;
    localparam logic [9:0] M1_VLAST = 10'd931;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblank;
        logic vblank;
        logic visible;
        logic hmax;
        logic vmax;
    } flags_t;

    // Flag decode for a given mode and position. Both sync pulses are
    // active-low in mode 0; mode 1 has a negative hsync and positive vsync.
    function automatic flags_t decode(input logic m, input logic [9:0] h, input logic [9:0] v);
        logic [9:0] hvis, hs0, hs1, hlast, vvis, vs0, vs1, vlast;
        logic       vneg;
        flags_t     f;
        if (m) begin
            hvis = M1_HVIS; hs0 = M1_HS0; hs1 = M1_HS1; hlast = M1_HLAST;
            vvis = M1_VVIS; vs0 = M1_VS0; vs1 = M1_VS1; vlast = M1_VLAST;
            vneg = 1'b0;
        end else begin
            hvis = M0_HVIS; hs0 = M0_HS0; hs1 = M0_HS1; hlast = M0_HLAST;
            vvis = M0_VVIS; vs0 = M0_VS0; vs1 = M0_VS1; vlast = M0_VLAST;
            vneg = 1'b1;
        end
        f.hblank  = (h >= hvis);
        f.vblank  = (v >= vvis);
        f.visible = ~f.hblank & ~f.vblank;
        f.hmax    = (h == hlast);
        f.vmax    = (v == vlast);
        f.hsync   = ~((h >= hs0) && (h < hs1));
        f.vsync   = ((v >= vs0) && (v < vs1)) ^ vneg;
        return f;
    endfunction

    logic [9:0] hpos_q, vpos_q, hpos_d, vpos_d;
    logic       mode_q, mode_d;
    logic       at_hmax, at_vmax;
    flags_t     flags;

    // Next position. The requested mode is only taken at the frame wrap, where
    // both counters return to zero, so a new mode never sees an out-of-range count.
    always_comb begin
        at_hmax = (hpos_q == (mode_q ? M1_HLAST : M0_HLAST));
        at_vmax = (vpos_q == (mode_q ? M1_VLAST : M0_VLAST));
        hpos_d  = at_hmax ? 10'd0 : hpos_q + 10'd1;
        vpos_d  = vpos_q;
        if (at_hmax) begin
            vpos_d = at_vmax ? 10'd0 : vpos_q + 10'd1;
        end
        mode_d  = (at_hmax && at_vmax) ? vga.mode : mode_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q <= 10'd0;
            vpos_q <= 10'd0;
            mode_q <= 1'b0;
        end else begin
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
            mode_q <= mode_d;
        end
    end

    generate
        if (REG_OUT) begin : g_reg_flags
            flags_t flags_q;
            // Decoding the next-state counters with the next-state mode keeps the
            // registered flags aligned with the counters they are clocked alongside,
            // including on the edge where the mode switches.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    flags_q <= decode(1'b0, 10'd0, 10'd0);
                end else begin
                    flags_q <= decode(mode_d, hpos_d, vpos_d);
                end
            end
            assign flags = flags_q;
        end else begin : g_comb_flags
            assign flags = decode(mode_q, hpos_q, vpos_q);
        end
    endgenerate

    assign vga.o_hpos    = hpos_q;
    assign vga.o_vpos    = vpos_q;
    assign vga.o_mode    = mode_q;
    assign vga.o_hsync   = flags.hsync;
    assign vga.o_vsync   = flags.vsync;
    assign vga.o_hblank  = flags.hblank;
    assign vga.o_vblank  = flags.vblank;
    assign vga.o_visible = flags.visible;
    assign vga.o_hmax    = flags.hmax;
    assign vga.o_vmax    = flags.vmax;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Drives a registered-output and a combinational-output generator side by
//   side from the same clock, reset and mode, compares both against an
//   independent raster model every cycle, and adds directed checks with
//   hand-computed values at the timing boundaries of both modes. To keep run
//   length short, the vertical counter is moved forward between clock edges
//   towards the interesting lines.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mode_in = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen_if if_r1();
    vga_timing_gen_if if_r0();

    assign if_r1.mode = mode_in;
    assign if_r0.mode = mode_in;

    vga_timing_gen #(.REG_OUT(1'b1)) dut_r1 (.clk(clk), .rst_n(rst_n), .vga(if_r1));
    vga_timing_gen #(.REG_OUT(1'b0)) dut_r0 (.clk(clk), .rst_n(rst_n), .vga(if_r0));

    int compared = 0;
    int mismatched = 0;

    // Timing tables, index 0 = 640x480, 1 = 1440x900/4
    localparam int HVIS [2] = '{640, 360};
    localparam int HFP  [2] = '{16, 20};
    localparam int HSW  [2] = '{96, 38};
    localparam int HTOT [2] = '{800, 476};
    localparam int VVIS [2] = '{480, 900};
    localparam int VFP  [2] = '{10, 1};
    localparam int VSW  [2] = '{2, 3};
    localparam int VTOT [2] = '{525, 932};
    localparam bit VNEG [2] = '{1'b1, 1'b0};

    // Reference raster position; a pending jump replaces the vertical count
    // the model advances from, just as the jump does inside the DUTs.
    logic [9:0] mh, mv, mvCur, jumpVal;
    logic       mmode;
    int         jumpSeq = 0;
    int         seenSeq;

    assign mvCur = (jumpSeq != seenSeq) ? jumpVal : mv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mh <= 10'd0;
            mv <= 10'd0;
            mmode <= 1'b0;
            seenSeq <= jumpSeq;
        end else begin
            seenSeq <= jumpSeq;
            if (int'(mh) == HTOT[mmode] - 1) begin
                mh <= 10'd0;
                if (int'(mvCur) == VTOT[mmode] - 1) begin
                    mv <= 10'd0;
                    mmode <= mode_in;
                end else begin
                    mv <= mvCur + 10'd1;
                end
            end else begin
                mh <= mh + 10'd1;
                mv <= mvCur;
            end
        end
    end

    function automatic logic [27:0] modelVec(input logic m, input logic [9:0] h, input logic [9:0] v);
        int  hi, vi;
        bit  hb, vb, hsAct, vsAct;
        hi = int'(h);
        vi = int'(v);
        hb = hi >= HVIS[m];
        vb = vi >= VVIS[m];
        hsAct = (hi >= HVIS[m] + HFP[m]) && (hi < HVIS[m] + HFP[m] + HSW[m]);
        vsAct = (vi >= VVIS[m] + VFP[m]) && (vi < VVIS[m] + VFP[m] + VSW[m]);
        return {h, v, !hsAct, VNEG[m] ? !vsAct : vsAct, hb, vb, !hb && !vb,
                hi == HTOT[m] - 1, vi == VTOT[m] - 1, m};
    endfunction

    function automatic logic [27:0] obsR1();
        return {if_r1.o_hpos, if_r1.o_vpos, if_r1.o_hsync, if_r1.o_vsync, if_r1.o_hblank,
                if_r1.o_vblank, if_r1.o_visible, if_r1.o_hmax, if_r1.o_vmax, if_r1.o_mode};
    endfunction

    function automatic logic [27:0] obsR0();
        return {if_r0.o_hpos, if_r0.o_vpos, if_r0.o_hsync, if_r0.o_vsync, if_r0.o_hblank,
                if_r0.o_vblank, if_r0.o_visible, if_r0.o_hmax, if_r0.o_vmax, if_r0.o_mode};
    endfunction

    // Reset levels: pos (0,0), hsync=1 vsync=1 hblank=0 vblank=0 visible=1 hmax=0 vmax=0 mode=0
    localparam logic [27:0] RESET_VEC = {10'd0, 10'd0, 8'b1100_1000};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Running totals over every sampled cycle of the registered-output DUT
    int cycTot = 0, hsLowTot = 0, hmaxTot = 0, visTot = 0;
    int cycM, hsLowM, hmaxM, visM;
    int maxH = 0, maxV = 0, maxV0 = 0;

    task automatic markCounts();
        cycM = cycTot;
        hsLowM = hsLowTot;
        hmaxM = hmaxTot;
        visM = visTot;
    endtask

    // One pixel: sample both DUTs half a clock after the active edge.
    task automatic tick();
        @(negedge clk);
        #1;
        checkOutput("raster_r1", 32'(obsR1()), 32'(modelVec(mmode, mh, mv)));
        checkOutput("raster_r0", 32'(obsR0()), 32'(modelVec(mmode, mh, mv)));
        cycTot++;
        if (!if_r1.o_hsync) hsLowTot++;
        if (if_r1.o_hmax) hmaxTot++;
        if (if_r1.o_visible) visTot++;
        if (int'(if_r1.o_hpos) > maxH) maxH = int'(if_r1.o_hpos);
        if (int'(if_r1.o_vpos) > maxV) maxV = int'(if_r1.o_vpos);
        if (!mmode && int'(if_r1.o_vpos) > maxV0) maxV0 = int'(if_r1.o_vpos);
    endtask

    task automatic waitPos(input int h, input int v);
        int n = 0;
        while (!(int'(mh) == h && int'(mv) == v) && n < 60000) begin
            tick();
            n++;
        end
        checkOutput("reach_pos", {12'd0, mh, mv}, {12'd0, 10'(h), 10'(v)});
    endtask

    // Move the vertical counter of both DUTs (and the model) between clock edges.
    task automatic jumpV(input logic [9:0] v);
        dut_r1.vpos_q = v;
        dut_r0.vpos_q = v;
        jumpVal = v;
        jumpSeq++;
    endtask

    task automatic applyStimulus();
        // reset state
        mode_in = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("reset_r1", 32'(obsR1()), 32'(RESET_VEC));
        checkOutput("reset_r0", 32'(obsR0()), 32'(RESET_VEC));
        @(negedge clk);
        #2 rst_n = 1'b1;

        // mode 0 horizontal boundaries
        waitPos(639, 0);  checkOutput("hblank@639", if_r1.o_hblank, 0);
        tick();           checkOutput("hblank@640", if_r1.o_hblank, 1);
                          checkOutput("visible@640", if_r1.o_visible, 0);
        waitPos(655, 0);  checkOutput("hsync@655", if_r1.o_hsync, 1);
        tick();           checkOutput("hsync@656", if_r1.o_hsync, 0);
        waitPos(751, 0);  checkOutput("hsync@751", if_r1.o_hsync, 0);
        tick();           checkOutput("hsync@752", if_r1.o_hsync, 1);
        waitPos(798, 0);  checkOutput("hmax@798", if_r1.o_hmax, 0);
        tick();           checkOutput("hmax@799", if_r1.o_hmax, 1);
        markCounts();
        waitPos(799, 1);
        checkOutput("m0_line_clks", cycTot - cycM, 800);
        checkOutput("m0_hsync_low", hsLowTot - hsLowM, 96);
        checkOutput("m0_hmax_per_line", hmaxTot - hmaxM, 1);
        checkOutput("m0_visible_line", visTot - visM, 640);
        tick();
        checkOutput("line_wrap", {12'd0, if_r1.o_hpos, if_r1.o_vpos}, {12'd0, 10'd0, 10'd2});

        // mode 0 vertical boundaries and frame wrap with a pending mode change
        jumpV(10'd478);
        waitPos(799, 479); checkOutput("vblank@479", if_r1.o_vblank, 0);
        tick();            checkOutput("vblank@480", if_r1.o_vblank, 1);
                           checkOutput("visible@v480", if_r1.o_visible, 0);
        waitPos(0, 489);   checkOutput("vsync@489", if_r1.o_vsync, 1);
        waitPos(0, 490);   checkOutput("vsync@490", if_r1.o_vsync, 0);
        waitPos(799, 491); checkOutput("vsync@491", if_r1.o_vsync, 0);
        tick();            checkOutput("vsync@492", if_r1.o_vsync, 1);
        waitPos(0, 500);
        mode_in = 1'b1;
        waitPos(475, 523); checkOutput("no_hmax@475_m0", if_r1.o_hmax, 0);
                           checkOutput("mode_held", if_r1.o_mode, 0);
        waitPos(798, 524); checkOutput("vmax_hmax@798", {if_r1.o_hmax, if_r1.o_vmax}, 2'b01);
        tick();            checkOutput("wrap_flags", {if_r1.o_hmax, if_r1.o_vmax}, 2'b11);
                           checkOutput("mode_before_wrap", if_r1.o_mode, 0);
        tick();            checkOutput("mode_after_wrap", if_r1.o_mode, 1);
                           checkOutput("frame_origin", {12'd0, if_r1.o_hpos, if_r1.o_vpos}, 0);
                           checkOutput("vsync_idle_m1", if_r1.o_vsync, 0);

        // mode 1 horizontal boundaries
        markCounts();
        waitPos(0, 1);
        checkOutput("m1_line_clks", cycTot - cycM, 476);
        checkOutput("m1_hsync_low", hsLowTot - hsLowM, 38);
        checkOutput("m1_hmax_per_line", hmaxTot - hmaxM, 1);
        checkOutput("m1_visible", visTot - visM, 360);
        waitPos(359, 1);  checkOutput("hblank@359", if_r1.o_hblank, 0);
        tick();           checkOutput("hblank@360", if_r1.o_hblank, 1);
        waitPos(379, 1);  checkOutput("hsync@379", if_r1.o_hsync, 1);
        tick();           checkOutput("hsync@380", if_r1.o_hsync, 0);
        waitPos(417, 1);  checkOutput("hsync@417", if_r1.o_hsync, 0);
        tick();           checkOutput("hsync@418", if_r1.o_hsync, 1);
        waitPos(474, 1);  checkOutput("hmax@474", if_r1.o_hmax, 0);
        tick();           checkOutput("hmax@475", if_r1.o_hmax, 1);
        tick();

        // mode 1 vertical boundaries, then drop back to mode 0 mid-frame
        jumpV(10'd898);
        waitPos(0, 899);   checkOutput("vblank@899", if_r1.o_vblank, 0);
        waitPos(0, 900);   checkOutput("vblank@900", if_r1.o_vblank, 1);
                           checkOutput("vsync@900", if_r1.o_vsync, 0);
        waitPos(0, 901);   checkOutput("vsync@901", if_r1.o_vsync, 1);
        waitPos(475, 903); checkOutput("vsync@903", if_r1.o_vsync, 1);
        tick();            checkOutput("vsync@904", if_r1.o_vsync, 0);
        waitPos(0, 910);
        mode_in = 1'b0;
        waitPos(475, 931); checkOutput("m1_wrap_flags", {if_r1.o_hmax, if_r1.o_vmax}, 2'b11);
                           checkOutput("m1_mode_held", if_r1.o_mode, 1);
        tick();            checkOutput("back_to_m0", if_r1.o_mode, 0);
                           checkOutput("vsync_idle_m0", if_r1.o_vsync, 1);
        markCounts();
        waitPos(0, 1);
        checkOutput("m0_again_line_clks", cycTot - cycM, 800);
        checkOutput("m0_again_hsync_low", hsLowTot - hsLowM, 96);

        // enter mode 1 again, then reset asynchronously at (300,200)
        mode_in = 1'b1;
        jumpV(10'd523);
        waitPos(0, 0);    checkOutput("m1_reentered", if_r1.o_mode, 1);
        tick();
        jumpV(10'd200);
        waitPos(300, 200);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_r1", 32'(obsR1()), 32'(RESET_VEC));
        checkOutput("async_reset_r0", 32'(obsR0()), 32'(RESET_VEC));
        tick();
        tick();
        #1 rst_n = 1'b1;
        checkOutput("release_hpos0", if_r1.o_hpos, 0);
        tick();           checkOutput("release_hpos1", if_r1.o_hpos, 1);
        tick();           checkOutput("release_hpos2", if_r1.o_hpos, 2);
                          checkOutput("release_mode", if_r1.o_mode, 0);
    endtask

    initial begin
        applyStimulus();
        checkOutput("max_hpos", maxH, 799);
        checkOutput("max_vpos", maxV, 931);
        checkOutput("max_vpos_m0", maxV0, 524);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
